// File: rtl/bcd_time_counter.sv
// BCD stopwatch / countdown timer: HH:MM:SS plus SUB_DIGITS fractional digits,
// with start/stop/clear/lap/load commands and wrap/done/load_err event pulses.
module bcd_time_counter #(
    parameter int SUB_DIGITS = 2,
    parameter int HR_MAX     = 23,
    localparam int N         = 6 + SUB_DIGITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           start,
    input  logic           stop,
    input  logic           clear,
    input  logic           lap,
    input  logic           down,
    input  logic           load,
    input  logic [4*N-1:0] load_bcd,
    output logic [4*N-1:0] disp_bcd,
    output logic           running,
    output logic           lap_active,
    output logic           wrap,
    output logic           done,
    output logic           load_err
);

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [N-1:0][3:0] cnt_q, cnt_d, cnt_inc, cnt_dec, snap_q, snap_d, ld_nib;
    logic              lap_q, lap_d;
    logic              wrap_d, done_d, lerr_d;
    logic [7:0]        hrs_q, ld_hrs;
    logic              inc_c, inc_wrap, dec_b, cnt_zero, dec_hits_zero;
    logic [N-3:0]      dig_ok;
    logic              load_ok, tick_en;

    // Upper limit of every digit below the hours pair (tens of seconds/minutes are 0..5).
    function automatic logic [3:0] dig_lim(input int i);
        return (i == SUB_DIGITS + 1 || i == SUB_DIGITS + 3) ? 4'd5 : 4'd9;
    endfunction

    assign ld_nib   = load_bcd;
    assign hrs_q    = 8'(cnt_q[N-1]) * 8'd10 + 8'(cnt_q[N-2]);
    assign ld_hrs   = 8'(ld_nib[N-1]) * 8'd10 + 8'(ld_nib[N-2]);
    assign cnt_zero = (cnt_q == '0);

    for (genvar g = 0; g < N - 2; g++) begin : g_lim
        assign dig_ok[g] = (ld_nib[g] <= dig_lim(g));
    end

    assign load_ok = (&dig_ok) && (ld_nib[N-1] <= 4'd9) && (ld_nib[N-2] <= 4'd9)
                     && (ld_hrs <= 8'(HR_MAX));

    // Increment with ripple carry; hours compare as a whole value against HR_MAX.
    always_comb begin
        cnt_inc  = cnt_q;
        inc_c    = 1'b1;
        inc_wrap = 1'b0;
        for (int i = 0; i < N - 2; i++) begin
            if (inc_c) begin
                if (cnt_q[i] == dig_lim(i)) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt_q[i] + 4'd1;
                    inc_c      = 1'b0;
                end
            end
        end
        if (inc_c) begin
            if (hrs_q == 8'(HR_MAX)) begin
                cnt_inc[N-1] = 4'd0;
                cnt_inc[N-2] = 4'd0;
                inc_wrap     = 1'b1;
            end else if (cnt_q[N-2] == 4'd9) begin
                cnt_inc[N-2] = 4'd0;
                cnt_inc[N-1] = cnt_q[N-1] + 4'd1;
            end else begin
                cnt_inc[N-2] = cnt_q[N-2] + 4'd1;
            end
        end
    end

    // Decrement with ripple borrow; an all-zero count stays at zero.
    always_comb begin
        cnt_dec = cnt_q;
        dec_b   = 1'b1;
        for (int i = 0; i < N - 2; i++) begin
            if (dec_b) begin
                if (cnt_q[i] == 4'd0) begin
                    cnt_dec[i] = dig_lim(i);
                end else begin
                    cnt_dec[i] = cnt_q[i] - 4'd1;
                    dec_b      = 1'b0;
                end
            end
        end
        if (dec_b) begin
            if (cnt_q[N-2] == 4'd0) begin
                cnt_dec[N-2] = 4'd9;
                cnt_dec[N-1] = cnt_q[N-1] - 4'd1;
            end else begin
                cnt_dec[N-2] = cnt_q[N-2] - 4'd1;
            end
        end
        if (cnt_zero) cnt_dec = cnt_q;
    end

    assign dec_hits_zero = !cnt_zero && (cnt_dec == '0);

    // Next state: tick counting first, then the single highest-priority command.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        lerr_d  = 1'b0;
        tick_en = (state_q == RUNNING) && tick && !clear;
        if (tick_en) begin
            if (down) begin
                cnt_d = cnt_dec;
                if (dec_hits_zero) begin
                    done_d  = 1'b1;
                    state_d = STOPPED;
                end
            end else begin
                cnt_d  = cnt_inc;
                wrap_d = inc_wrap;
            end
        end
        if (clear) begin
            cnt_d   = '0;
            state_d = STOPPED;
            lap_d   = 1'b0;
        end else if (load) begin
            // A load while running is silently ignored.
            if (state_q == STOPPED) begin
                if (load_ok) cnt_d  = ld_nib;
                else         lerr_d = 1'b1;
            end
        end else if (stop) begin
            state_d = STOPPED;
        end else if (start) begin
            if (state_q == STOPPED) state_d = RUNNING;
        end else if (lap) begin
            lap_d = !lap_q;
            if (!lap_q) snap_d = cnt_d;
        end
    end

    // State, count, snapshot and event-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STOPPED;
            cnt_q    <= '0;
            snap_q   <= '0;
            lap_q    <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            lap_q    <= lap_d;
            wrap     <= wrap_d;
            done     <= done_d;
            load_err <= lerr_d;
        end
    end

    // Display register: live count or frozen snapshot, one cycle behind the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp_bcd <= '0;
        else     disp_bcd <= lap_q ? snap_q : cnt_q;
    end

    assign running    = (state_q == RUNNING);
    assign lap_active = lap_q;

endmodule
